// File: rtl/logic_gate_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit AND/OR/NOT unit among NREQ requesters.
// Optional feature macro: LOGIC_ARB_XOR_EN (opcode 11 becomes XOR instead of an error result).
module logic_gate_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [NREQ-1:0]          iReqValid,
  input  logic [NREQ*WIDTH-1:0]    iReqA,
  input  logic [NREQ*WIDTH-1:0]    iReqB,
  input  logic [NREQ*2-1:0]        iReqOp,
  output logic [NREQ-1:0]          oReqReady,
  output logic                     oResValid,
  output logic [WIDTH-1:0]         oResData,
  output logic [$clog2(NREQ)-1:0]  oResId,
  output logic                     oResErr,
  input  logic                     iResReady,
  output logic                     oBusy,
  output logic [CNTW-1:0]          oOpCount
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   next_ptr;
  logic [IDW-1:0]   cand_idx;
  logic             grant_found;
  logic [NREQ-1:0]  grant;
  logic             transfer;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] alu_data;
  logic             alu_err;
  int               cand;

  // Search for the first valid requester starting at the round-robin pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand     = (int'(rr_ptr) + off) % NREQ;
      cand_idx = IDW'(cand);
      if (!grant_found && iReqValid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE && !iRst && grant_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign oReqReady = grant;
  assign transfer  = |grant;
  assign oBusy     = (state == BUSY);

  assign sel_a  = iReqA[grant_idx*WIDTH +: WIDTH];
  assign sel_b  = iReqB[grant_idx*WIDTH +: WIDTH];
  assign sel_op = iReqOp[grant_idx*2 +: 2];

  assign next_ptr = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  // Shared bitwise unit; opcode 11 depends on the build-time XOR option.
  always_comb begin
    alu_data = '0;
    alu_err  = 1'b0;
    case (sel_op)
      2'b00:   alu_data = sel_a & sel_b;
      2'b01:   alu_data = sel_a | sel_b;
      2'b10:   alu_data = ~sel_a;
      default: begin
`ifdef LOGIC_ARB_XOR_EN
        alu_data = sel_a ^ sel_b;
`else
        alu_err  = 1'b1;
`endif
      end
    endcase
  end

  // Result register is only loaded on a transfer, so it stays stable while held.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      oResValid <= 1'b0;
      oResData  <= '0;
      oResId    <= '0;
      oResErr   <= 1'b0;
      oOpCount  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            oResData  <= alu_data;
            oResErr   <= alu_err;
            oResId    <= grant_idx;
            oResValid <= 1'b1;
            rr_ptr    <= next_ptr;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (iResReady) begin
            oResValid <= 1'b0;
            oOpCount  <= oOpCount + CNTW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
